riscv_muldiv_unit: RTL and testbench

- Parametrised iterative multiply/divide unit implementing the RV32M/RV64M MUL*/DIV*/REM* operations for the pipelined core.
- Sits beside the EX-stage ALU. The pipeline issues an operation through a valid/ready handshake and holds EX stalled until the result handshake completes.
- New capabilities: selectable XLEN, selectable radix (bits retired per cycle) and a flush input for branch mispredict or exception kill.

---
 rtl/riscv_muldiv_unit_pkg.sv | 24 ++
 rtl/riscv_muldiv_unit_if.sv | 26 ++
 rtl/riscv_muldiv_unit_step.sv | 34 +++
 rtl/riscv_muldiv_unit.sv | 122 ++++++++++++
 tb/tb_riscv_muldiv_unit.sv | 258 +++++++++++++++++++++++++
 5 files changed

// File: rtl/riscv_muldiv_unit_pkg.sv
// Shared M-extension definitions: funct3 encodings, unit FSM states, operand signedness.
// Used by the interface, the top module and the bench.
package riscv_m_pkg;

  localparam logic [2:0] M_MUL    = 3'd0;
  localparam logic [2:0] M_MULH   = 3'd1;
  localparam logic [2:0] M_MULHSU = 3'd2;
  localparam logic [2:0] M_MULHU  = 3'd3;
  localparam logic [2:0] M_DIV    = 3'd4;
  localparam logic [2:0] M_DIVU   = 3'd5;
  localparam logic [2:0] M_REM    = 3'd6;
  localparam logic [2:0] M_REMU   = 3'd7;

  typedef enum logic [1:0] {S_IDLE, S_MUL, S_DIV, S_DONE} state_t;

  function automatic logic is_signed_a(input logic [2:0] f3);
    return (f3 == M_MULH) || (f3 == M_MULHSU) || (f3 == M_DIV) || (f3 == M_REM);
  endfunction

  function automatic logic is_signed_b(input logic [2:0] f3);
    return (f3 == M_MULH) || (f3 == M_DIV) || (f3 == M_REM);
  endfunction

endpackage

// File: rtl/riscv_muldiv_unit_if.sv
// EX-stage <-> mul/div unit bundle: request valid/ready, result valid/ready, flush and busy.
// master = pipeline side, slave = unit side.
interface riscv_muldiv_unit_if #(parameter int XLEN = 32);

  logic            in_valid;
  logic            in_ready;
  logic [2:0]      funct3;
  logic [XLEN-1:0] op_a;
  logic [XLEN-1:0] op_b;
  logic            flush;
  logic            out_valid;
  logic            out_ready;
  logic [XLEN-1:0] result;
  logic            busy;

  modport master (
    output in_valid, funct3, op_a, op_b, flush, out_ready,
    input  in_ready, out_valid, result, busy
  );

  modport slave (
    input  in_valid, funct3, op_a, op_b, flush, out_ready,
    output in_ready, out_valid, result, busy
  );

endinterface

// File: rtl/riscv_muldiv_unit_step.sv
// One combinational iteration on a {hi,lo} register pair: shift-add (MUL) or restoring subtract (DIV).
// Chained STEP times per cycle by the top module.
module riscv_muldiv_step #(
  parameter int XLEN = 32
) (
  input  logic            i_is_div,
  input  logic [XLEN-1:0] i_hi,
  input  logic [XLEN-1:0] i_lo,
  input  logic [XLEN-1:0] i_opnd,
  output logic [XLEN-1:0] o_hi,
  output logic [XLEN-1:0] o_lo
);

  logic [XLEN:0] w_sum;
  logic [XLEN:0] w_shift;
  logic [XLEN:0] w_diff;
  logic          w_ge;

  always_comb begin
    w_sum   = {1'b0, i_hi} + (i_lo[0] ? {1'b0, i_opnd} : '0);
    w_shift = {i_hi, i_lo[XLEN-1]};
    w_diff  = w_shift - {1'b0, i_opnd};
    // Partial remainder stays below the divisor, so the borrow bit alone decides the compare.
    w_ge    = ~w_diff[XLEN];
    if (i_is_div) begin
      o_hi = w_ge ? w_diff[XLEN-1:0] : w_shift[XLEN-1:0];
      o_lo = {i_lo[XLEN-2:0], w_ge};
    end else begin
      o_hi = w_sum[XLEN:1];
      o_lo = {w_sum[0], i_lo[XLEN-1:1]};
    end
  end

endmodule

// File: rtl/riscv_muldiv_unit.sv
// Iterative RV32M/RV64M mul/div: XLEN/STEP iteration cycles, special divides finish in one cycle.
// Result held in DONE until out_ready; flush kills any state; in_ready only in IDLE.
module riscv_muldiv_unit
  import riscv_m_pkg::*;
#(
  parameter int XLEN = 32,
  parameter int STEP = 1
) (
  input  logic                 clk,
  input  logic                 reset,
  riscv_muldiv_unit_if.slave   bus
);

  localparam int ITER = XLEN / STEP;
  localparam int CW   = $clog2(ITER + 1);

  state_t          r_state, w_next;
  logic [2:0]      r_f3;
  logic            r_neg_a, r_neg_b;
  logic [XLEN-1:0] r_hi, r_lo, r_opnd, r_result;
  logic [CW-1:0]   r_cnt;

  logic              w_accept, w_last, w_is_div, w_div_zero, w_ovf, w_special;
  logic [XLEN-1:0]   w_abs_a, w_abs_b, w_spec_res, w_quo, w_rem, w_final;
  logic [2*XLEN-1:0] w_prod;
  logic [XLEN-1:0]   w_chain_hi [STEP+1];
  logic [XLEN-1:0]   w_chain_lo [STEP+1];

  always_comb begin
    w_accept   = bus.in_valid && (r_state == S_IDLE) && !bus.flush;
    w_abs_a    = (is_signed_a(bus.funct3) && bus.op_a[XLEN-1]) ? -bus.op_a : bus.op_a;
    w_abs_b    = (is_signed_b(bus.funct3) && bus.op_b[XLEN-1]) ? -bus.op_b : bus.op_b;
    w_div_zero = bus.funct3[2] && (bus.op_b == '0);
    w_ovf      = ((bus.funct3 == M_DIV) || (bus.funct3 == M_REM)) &&
                 (bus.op_a == {1'b1, {(XLEN-1){1'b0}}}) && (bus.op_b == '1);
    w_special  = w_div_zero || w_ovf;
    if (w_div_zero) w_spec_res = bus.funct3[1] ? bus.op_a : '1;
    else            w_spec_res = bus.funct3[1] ? '0 : bus.op_a;
    w_last     = (r_cnt == CW'(ITER - 1));
    w_is_div   = (r_state == S_DIV);
  end

  assign w_chain_hi[0] = r_hi;
  assign w_chain_lo[0] = r_lo;

  for (genvar g = 0; g < STEP; g++) begin : g_step
    riscv_muldiv_step #(.XLEN(XLEN)) u_step (
      .i_is_div (w_is_div),
      .i_hi     (w_chain_hi[g]),
      .i_lo     (w_chain_lo[g]),
      .i_opnd   (r_opnd),
      .o_hi     (w_chain_hi[g+1]),
      .o_lo     (w_chain_lo[g+1])
    );
  end

  // Single sign fix-up stage applied on the final iteration.
  always_comb begin
    w_prod = {w_chain_hi[STEP], w_chain_lo[STEP]};
    if (r_neg_a ^ r_neg_b) w_prod = -w_prod;
    w_quo = (r_neg_a ^ r_neg_b) ? -w_chain_lo[STEP] : w_chain_lo[STEP];
    w_rem = r_neg_a ? -w_chain_hi[STEP] : w_chain_hi[STEP];
    if (w_is_div)            w_final = r_f3[1] ? w_rem : w_quo;
    else if (r_f3 == M_MUL)  w_final = w_prod[XLEN-1:0];
    else                     w_final = w_prod[2*XLEN-1:XLEN];
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) r_state <= S_IDLE;
    else        r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    if (bus.flush) begin
      w_next = S_IDLE;
    end else begin
      case (r_state)
        S_IDLE:       if (w_accept) w_next = w_special ? S_DONE : (bus.funct3[2] ? S_DIV : S_MUL);
        S_MUL, S_DIV: if (w_last) w_next = S_DONE;
        S_DONE:       if (bus.out_ready) w_next = S_IDLE;
        default:      w_next = S_IDLE;
      endcase
    end
  end

  always_comb begin
    bus.in_ready  = (r_state == S_IDLE);
    bus.out_valid = (r_state == S_DONE);
    bus.busy      = (r_state != S_IDLE);
    bus.result    = r_result;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_f3     <= '0;
      r_neg_a  <= 1'b0;
      r_neg_b  <= 1'b0;
      r_hi     <= '0;
      r_lo     <= '0;
      r_opnd   <= '0;
      r_result <= '0;
      r_cnt    <= '0;
    end else if (w_accept) begin
      r_f3    <= bus.funct3;
      r_neg_a <= is_signed_a(bus.funct3) && bus.op_a[XLEN-1];
      r_neg_b <= is_signed_b(bus.funct3) && bus.op_b[XLEN-1];
      r_hi    <= '0;
      r_cnt   <= '0;
      // DIV shifts the dividend out of lo; MUL shifts the multiplier out of lo.
      r_lo    <= bus.funct3[2] ? w_abs_a : w_abs_b;
      r_opnd  <= bus.funct3[2] ? w_abs_b : w_abs_a;
      if (w_special) r_result <= w_spec_res;
    end else if (((r_state == S_MUL) || (r_state == S_DIV)) && !bus.flush) begin
      r_hi  <= w_chain_hi[STEP];
      r_lo  <= w_chain_lo[STEP];
      r_cnt <= r_cnt + CW'(1);
      if (w_last) r_result <= w_final;
    end
  end

endmodule

// File: tb/tb_riscv_muldiv_unit.sv
// Bench for riscv_muldiv_unit: directed vector table, hand sequences for back-pressure/flush/reset,
// and random ops on 32/1 and 64/4 instances checked against a plain-arithmetic model.
module tb_riscv_muldiv_unit;

  logic clk = 1'b0;
  logic rst32 = 1'b0;
  logic rst64 = 1'b0;
  int   n_checks = 0;
  int   n_err = 0;

  always #5 clk = ~clk;

  riscv_muldiv_unit_if #(.XLEN(32)) if32();
  riscv_muldiv_unit_if #(.XLEN(64)) if64();

  riscv_muldiv_unit #(.XLEN(32), .STEP(1)) u_dut32 (.clk(clk), .reset(rst32), .bus(if32));
  riscv_muldiv_unit #(.XLEN(64), .STEP(4)) u_dut64 (.clk(clk), .reset(rst64), .bus(if64));

  typedef struct {
    string       name;
    logic [2:0]  f3;
    logic [63:0] a;
    logic [63:0] b;
    logic [63:0] exp;
    int          lat;
  } vec_t;

  task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
    end
  endtask

  // {in_ready, out_valid, busy}
  function automatic logic [2:0] status(input int w);
    if (w == 0) return {if32.in_ready, if32.out_valid, if32.busy};
    return {if64.in_ready, if64.out_valid, if64.busy};
  endfunction

  function automatic logic [63:0] res_of(input int w);
    if (w == 0) return {32'b0, if32.result};
    return if64.result;
  endfunction

  task automatic set_in(input int w, input logic v, input logic [2:0] f3,
                        input logic [63:0] a, input logic [63:0] b);
    if (w == 0) begin
      if32.in_valid = v; if32.funct3 = f3; if32.op_a = a[31:0]; if32.op_b = b[31:0];
    end else begin
      if64.in_valid = v; if64.funct3 = f3; if64.op_a = a; if64.op_b = b;
    end
  endtask

  task automatic set_ord(input int w, input logic v);
    if (w == 0) if32.out_ready = v;
    else        if64.out_ready = v;
  endtask

  // Reference: sign/zero extend to 128 bits and use native arithmetic.
  function automatic logic [63:0] model(input int xl, input logic [2:0] f3,
                                        input logic [63:0] a_in, input logic [63:0] b_in);
    logic [63:0]        mask, a, b;
    logic signed [127:0] sa, sb, za, zb, p;
    logic [127:0]        u;
    mask = (xl == 64) ? '1 : 64'hFFFF_FFFF;
    a = a_in & mask;
    b = b_in & mask;
    za = {64'b0, a};
    zb = {64'b0, b};
    sa = (xl == 64) ? {{64{a[63]}}, a} : {{96{a[31]}}, a[31:0]};
    sb = (xl == 64) ? {{64{b[63]}}, b} : {{96{b[31]}}, b[31:0]};
    case (f3)
      3'd0: p = sa * sb;
      3'd1: p = sa * sb;
      3'd2: p = sa * zb;
      3'd3: p = za * zb;
      3'd4: p = (b == 0) ? -128'sd1 : sa / sb;
      3'd5: p = (b == 0) ? -128'sd1 : za / zb;
      3'd6: p = (b == 0) ? za : sa % sb;
      default: p = (b == 0) ? za : za % zb;
    endcase
    u = p;
    if (f3 != 3'd0 && f3[2] == 1'b0) u = u >> xl;
    return u[63:0] & mask;
  endfunction

  function automatic logic is_special(input int xl, input logic [2:0] f3,
                                      input logic [63:0] a, input logic [63:0] b);
    logic [63:0] mask, minv;
    mask = (xl == 64) ? '1 : 64'hFFFF_FFFF;
    minv = (xl == 64) ? 64'h8000_0000_0000_0000 : 64'h8000_0000;
    return f3[2] && (((b & mask) == 0) ||
           (!f3[0] && ((a & mask) == minv) && ((b & mask) == mask)));
  endfunction

  function automatic logic [63:0] pick(input int xl);
    logic [63:0] v;
    case ($urandom_range(0, 5))
      0: v = 64'd0;
      1: v = '1;
      2: v = (xl == 64) ? 64'h8000_0000_0000_0000 : 64'h8000_0000;
      3: v = 64'($urandom_range(0, 20));
      4: v = -64'($urandom_range(1, 20));
      default: v = {$urandom, $urandom};
    endcase
    return (xl == 64) ? v : (v & 64'hFFFF_FFFF);
  endfunction

  task automatic do_op(input int w, input logic [2:0] f3, input logic [63:0] a,
                       input logic [63:0] b, input logic [63:0] exp, input int lat,
                       input string nm);
    int   c;
    logic ov;
    @(negedge clk);
    check({nm, " ready"}, 64'(status(w)), 64'(3'b100));
    set_in(w, 1'b1, f3, a, b);
    @(posedge clk); #1;
    set_in(w, 1'b0, 3'($urandom), {$urandom, $urandom}, {$urandom, $urandom});
    c = 0;
    ov = 1'b0;
    while (!ov && c < 200) begin
      @(negedge clk);
      c++;
      ov = status(w)[1];
    end
    check({nm, " latency"}, 64'(c), 64'(lat));
    check({nm, " result"}, res_of(w), exp);
    set_ord(w, 1'b1);
    @(posedge clk); #1;
    set_ord(w, 1'b0);
    @(negedge clk);
    check({nm, " retire"}, 64'(status(w)), 64'(3'b100));
  endtask

  vec_t vecs[11];

  initial begin
    #3_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int   c;
    logic seen;
    logic [63:0] a, b;
    logic [2:0]  f3;

    vecs[0]  = '{"MUL 7*-3",       3'd0, 64'd7,           64'hFFFF_FFFD, 64'hFFFF_FFEB, 33};
    vecs[1]  = '{"MULH 7*-3",      3'd1, 64'd7,           64'hFFFF_FFFD, 64'hFFFF_FFFF, 33};
    vecs[2]  = '{"MULHU 7*-3",     3'd3, 64'd7,           64'hFFFF_FFFD, 64'h0000_0006, 33};
    vecs[3]  = '{"DIV -20/3",      3'd4, 64'hFFFF_FFEC,   64'd3,         64'hFFFF_FFFA, 33};
    vecs[4]  = '{"REM -20/3",      3'd6, 64'hFFFF_FFEC,   64'd3,         64'hFFFF_FFFE, 33};
    vecs[5]  = '{"DIVU 100/7",     3'd5, 64'd100,         64'd7,         64'd14,        33};
    vecs[6]  = '{"REMU 100/7",     3'd7, 64'd100,         64'd7,         64'd2,         33};
    vecs[7]  = '{"DIVU 5/0",       3'd5, 64'd5,           64'd0,         64'hFFFF_FFFF, 1};
    vecs[8]  = '{"REM 5/0",        3'd6, 64'd5,           64'd0,         64'd5,         1};
    vecs[9]  = '{"DIV ovf",        3'd4, 64'h8000_0000,   64'hFFFF_FFFF, 64'h8000_0000, 1};
    vecs[10] = '{"REM ovf",        3'd6, 64'h8000_0000,   64'hFFFF_FFFF, 64'd0,         1};

    set_in(0, 1'b0, 3'd0, 64'd0, 64'd0);
    set_in(1, 1'b0, 3'd0, 64'd0, 64'd0);
    if32.flush = 1'b0; if64.flush = 1'b0;
    set_ord(0, 1'b0); set_ord(1, 1'b0);

    #12;
    check("reset32 status", 64'(status(0)), 64'(3'b100));
    check("reset32 result", res_of(0), 64'd0);
    check("reset64 status", 64'(status(1)), 64'(3'b100));
    check("reset64 result", res_of(1), 64'd0);
    @(negedge clk);
    rst32 = 1'b1;
    rst64 = 1'b1;

    foreach (vecs[i]) do_op(0, vecs[i].f3, vecs[i].a, vecs[i].b, vecs[i].exp, vecs[i].lat, vecs[i].name);

    // Back-pressure: result held with out_ready low, new requests ignored.
    @(negedge clk);
    set_in(0, 1'b1, 3'd3, 64'd7, 64'hFFFF_FFFD);
    @(posedge clk); #1;
    set_in(0, 1'b1, 3'd0, 64'd9, 64'd9);
    c = 0;
    while (!status(0)[1] && c < 200) begin @(negedge clk); c++; end
    check("bp latency", 64'(c), 64'd33);
    for (int i = 0; i < 10; i++) begin
      check("bp status", 64'(status(0)), 64'(3'b011));
      check("bp result", res_of(0), 64'd6);
      @(negedge clk);
    end
    set_in(0, 1'b0, 3'd0, 64'd0, 64'd0);
    set_ord(0, 1'b1);
    @(posedge clk); #1;
    set_ord(0, 1'b0);
    @(negedge clk);
    check("bp release", 64'(status(0)), 64'(3'b100));

    // Flush at cycle 10 of a DIV.
    set_in(0, 1'b1, 3'd4, 64'd1000, 64'd7);
    @(posedge clk); #1;
    set_in(0, 1'b0, 3'd0, 64'd0, 64'd0);
    for (int i = 1; i < 10; i++) @(negedge clk);
    if32.flush = 1'b1;
    @(posedge clk); #1;
    if32.flush = 1'b0;
    @(negedge clk);
    check("flush idle", 64'(status(0)), 64'(3'b100));
    seen = 1'b0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (status(0)[1]) seen = 1'b1;
    end
    check("flush no result", 64'(seen), 64'd0);
    set_in(0, 1'b1, 3'd0, 64'd3, 64'd3);
    if32.flush = 1'b1;
    @(posedge clk); #1;
    set_in(0, 1'b0, 3'd0, 64'd0, 64'd0);
    if32.flush = 1'b0;
    @(negedge clk);
    check("flush blocks accept", 64'(status(0)), 64'(3'b100));
    do_op(0, 3'd3, 64'hFFFF_FFFF, 64'hFFFF_FFFF, 64'hFFFF_FFFE, 33, "MULHU after flush");

    // 64-bit, 4 bits per cycle.
    do_op(1, 3'd0, 64'h1_0000_0001, 64'd3, 64'h3_0000_0003, 17, "MUL64");

    // Asynchronous reset in the middle of a 64-bit op.
    @(negedge clk);
    set_in(1, 1'b1, 3'd0, 64'h1234_5678_9ABC_DEF0, 64'd77);
    @(posedge clk); #1;
    set_in(1, 1'b0, 3'd0, 64'd0, 64'd0);
    for (int i = 0; i < 5; i++) @(negedge clk);
    check("mid-op busy", 64'(status(1)), 64'(3'b001));
    #2 rst64 = 1'b0;
    #1;
    check("async reset status", 64'(status(1)), 64'(3'b100));
    check("async reset result", res_of(1), 64'd0);
    @(negedge clk);
    rst64 = 1'b1;

    for (int w = 0; w < 2; w++) begin
      for (int i = 0; i < 40; i++) begin
        int xl;
        xl = (w == 0) ? 32 : 64;
        a  = pick(xl);
        b  = pick(xl);
        f3 = 3'($urandom_range(0, 7));
        do_op(w, f3, a, b, model(xl, f3, a, b),
              is_special(xl, f3, a, b) ? 1 : ((w == 0) ? 33 : 17),
              $sformatf("rand%0d f3=%0d a=%0h b=%0h", xl, f3, a, b));
      end
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
    $finish;
  end

endmodule
